// File: rtl/mcamcs_v2.sv
// Multi-channel-analyser peak capture.
// On each trigger edge it opens a window, tracks the signed peak and where in the window it
// occurred, flags pile-up, and timestamps the event. Each finished event becomes a record in a
// small show-ahead FIFO with a valid/ready handshake. Records that find the FIFO full are
// dropped and counted.
module mcamcs_v2 #(
  parameter int unsigned DW     = 14,
  parameter int unsigned TW     = 18,
  parameter int unsigned TSHIFT = 7,
  parameter int unsigned CW     = 64,
  parameter int unsigned WINW   = 11,
  parameter int unsigned FDEPTH = 4,
  parameter int unsigned OFFBIN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trg,
  input  logic [DW-1:0]   ain,
  input  logic            enable,
  input  logic [WINW-1:0] win_len,
  output logic [DW-1:0]   pout,
  output logic [TW-1:0]   tout,
  output logic [WINW-1:0] ppos,
  output logic            pileup,
  output logic            ovalid,
  input  logic            oready,
  output logic [15:0]     drop_cnt,
  output logic            busy
);

  localparam int unsigned AW = $clog2(FDEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [WINW-1:0] LEN_ONE  = WINW'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(FDEPTH);
  localparam logic [CW-1:0]   TICK_ONE = CW'(1);

  logic [CW-1:0]          r_cnt;
  logic                   r_trg_d;
  logic [1:0]             r_state;
  logic [WINW-1:0]        r_len;
  logic [WINW-1:0]        r_wcnt;
  logic [WINW-1:0]        r_pos;
  logic [TW-1:0]          r_ts;
  logic signed [DW-1:0]   r_peak;
  logic                   r_pu;
  logic [15:0]            r_drop;

  logic [DW-1:0]          r_mem_peak [FDEPTH];
  logic [TW-1:0]          r_mem_ts   [FDEPTH];
  logic [WINW-1:0]        r_mem_pos  [FDEPTH];
  logic                   r_mem_pu   [FDEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_count;

  logic                   w_edge;
  logic signed [DW-1:0]   w_step0;
  logic [WINW-1:0]        w_len_eff;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_rec_pu;

  assign w_edge    = trg & ~r_trg_d;
  // Offset-binary samples become two's complement by flipping the MSB.
  assign w_step0   = (OFFBIN != 0) ? {~ain[DW-1], ain[DW-2:0]} : ain;
  assign w_len_eff = (win_len == '0) ? LEN_ONE : win_len;
  assign w_full    = (r_count == CNT_FULL);
  assign w_pop     = ovalid & oready;
  // A pop in the same cycle frees a slot, even when the FIFO is full.
  assign w_push    = (r_state == S_EMIT) & (~w_full | w_pop);
  assign w_drop    = (r_state == S_EMIT) & w_full & ~w_pop;
  // A trigger edge during EMIT still marks the outgoing record as piled up.
  assign w_rec_pu  = r_pu | w_edge;

  // Free-running timestamp counter and trigger delay register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_trg_d <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + TICK_ONE;
      r_trg_d <= trg;
    end
  end

  // Window control FSM and peak tracking datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_pos   <= '0;
      r_ts    <= '0;
      r_peak  <= '0;
      r_pu    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && w_edge) begin
            r_len   <= w_len_eff;
            r_ts    <= r_cnt[TSHIFT+TW-1:TSHIFT];
            r_peak  <= w_step0;
            r_pos   <= '0;
            r_pu    <= 1'b0;
            r_wcnt  <= LEN_ONE;
            r_state <= (w_len_eff == LEN_ONE) ? S_EMIT : S_ACQ;
          end
        end
        S_ACQ: begin
          // Strict compare keeps the earliest position on ties.
          if (w_step0 > r_peak) begin
            r_peak <= w_step0;
            r_pos  <= r_wcnt;
          end
          if (w_edge) begin
            r_pu <= 1'b1;
          end
          if (r_wcnt == r_len - LEN_ONE) begin
            r_state <= S_EMIT;
          end else begin
            r_wcnt <= r_wcnt + LEN_ONE;
          end
        end
        S_EMIT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents are only visible through valid entries, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_peak[r_wptr] <= r_peak;
      r_mem_ts[r_wptr]   <= r_ts;
      r_mem_pos[r_wptr]  <= r_pos;
      r_mem_pu[r_wptr]   <= w_rec_pu;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of records lost to a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  assign ovalid   = (r_count != '0);
  assign pout     = ovalid ? r_mem_peak[r_rptr] : '0;
  assign tout     = ovalid ? r_mem_ts[r_rptr]   : '0;
  assign ppos     = ovalid ? r_mem_pos[r_rptr]  : '0;
  assign pileup   = ovalid ? r_mem_pu[r_rptr]   : 1'b0;
  assign drop_cnt = r_drop;
  assign busy     = (r_state != S_IDLE);

endmodule
